// File: rtl/tioe1_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tioe1_pkg
//  Brief    : Shared definitions for the truth-table sweeper: FSM state
//             encoding, default input count, table and counter widths.
//  Revision : 1.0 - initial release
// ============================================================================
package tioe1_pkg;

    // Default number of inputs of the function block (A,B,C,D)
    localparam int unsigned N_IN_DEF = 4;

    // Truth table width for the default input count
    localparam int unsigned TABLE_W  = 2**N_IN_DEF;

    // Settle counter width; covers the legal settle range 0..15
    localparam int unsigned CNT_W    = 4;

    // Sweep sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FINISH = 2'd3
    } sweep_state_e;

endpackage : tioe1_pkg
`default_nettype wire

// File: rtl/sweep_settle_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : sweep_settle_cnt
//  Brief    : Loadable down-counter with a terminal flag. The flag marks the
//             last wait cycle (count == 1) so the sequencer can leave its
//             wait state on that same edge.
//  Revision : 1.0 - initial release
// ============================================================================
module sweep_settle_cnt
    import tioe1_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    input  logic                 dec,
    output logic                 at_one
);

    localparam logic [CNT_WIDTH-1:0] c_one  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_zero = '0;

    logic [CNT_WIDTH-1:0] r_count;

    // Load has priority over decrement; the count never wraps below zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= c_zero;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != c_zero)) begin
            r_count <= r_count - c_one;
        end
    end

    assign at_one = (r_count == c_one);

endmodule : sweep_settle_cnt
`default_nettype wire

// File: rtl/tioe1_sweeper.sv
`default_nettype none
// ============================================================================
//  Module   : tioe1_sweeper
//  Brief    : Clocked stimulus/capture stage for a combinational function
//             block. Walks in_vec through every input combination in
//             ascending order, waits SETTLE cycles per combination, samples
//             F, and reports the captured truth table, its minterm count and
//             a compare against an expected table.
//  Revision : 1.0 - initial release
// ============================================================================
module tioe1_sweeper
    import tioe1_pkg::*;
#(
    parameter int unsigned N_IN   = N_IN_DEF,
    parameter int unsigned SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 f_in,
    input  logic [2**N_IN-1:0]   exp_table,
    output logic [N_IN-1:0]      in_vec,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic [N_IN:0]        ones_cnt,
    output logic                 match
);

    localparam logic [N_IN-1:0]  c_idx_last = '1;
    localparam logic [N_IN-1:0]  c_idx_one  = N_IN'(1);
    localparam logic [N_IN:0]    c_cnt_one  = (N_IN+1)'(1);
    localparam logic [CNT_W-1:0] c_settle   = CNT_W'(SETTLE);
    localparam bit               c_no_wait  = (SETTLE == 0);

    sweep_state_e          r_state;
    logic [N_IN-1:0]       r_idx;
    logic [2**N_IN-1:0]    w_table_next;
    logic                  w_cnt_load;
    logic                  w_cnt_dec;
    logic                  w_cnt_at_one;
    logic                  w_last;

    assign w_last = (r_idx == c_idx_last);

    // Table as it will look after the current sample; lets match be
    // computed on the same edge that captures the final bit
    always_comb begin
        w_table_next        = table_out;
        w_table_next[r_idx] = f_in;
    end

    // Reload the wait on sweep start and whenever a new combination begins
    assign w_cnt_load = ((r_state == ST_IDLE) && start) ||
                        ((r_state == ST_SAMPLE) && !w_last);
    assign w_cnt_dec  = (r_state == ST_SETTLE);

    sweep_settle_cnt #(
        .CNT_WIDTH (CNT_W)
    ) u_settle_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_cnt_load),
        .load_val (c_settle),
        .dec      (w_cnt_dec),
        .at_one   (w_cnt_at_one)
    );

    // idx is the applied combination; it returns to 0 when the sweep ends
    assign in_vec = r_idx;

    // Sweep sequencer with registered status and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            table_out <= '0;
            ones_cnt  <= '0;
            match     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        table_out <= '0;
                        ones_cnt  <= '0;
                        match     <= 1'b0;
                        r_idx     <= '0;
                        busy      <= 1'b1;
                        r_state   <= c_no_wait ? ST_SAMPLE : ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (w_cnt_at_one) begin
                        r_state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    table_out <= w_table_next;
                    if (f_in) begin
                        ones_cnt <= ones_cnt + c_cnt_one;
                    end
                    if (w_last) begin
                        done    <= 1'b1;
                        match   <= (w_table_next == exp_table);
                        r_state <= ST_FINISH;
                    end else begin
                        r_idx   <= r_idx + c_idx_one;
                        r_state <= c_no_wait ? ST_SAMPLE : ST_SETTLE;
                    end
                end
                ST_FINISH: begin
                    busy    <= 1'b0;
                    r_idx   <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : tioe1_sweeper
`default_nettype wire

// File: tb/tb_tioe1_sweeper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tioe1_sweeper
//  Brief    : Self-checking bench for tioe1_sweeper. Two instances share the
//             clock and reset: u_dut1 waits one settle cycle, u_dut0 none.
//             Each drives a lookup-table function block; expected results
//             are derived from that function table directly.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tioe1_sweeper;

    logic        clk;
    logic        rst;
    logic        start1, start0;
    logic [15:0] fn1, fn0;
    logic [15:0] exp1, exp0;
    logic        f_in1, f_in0;
    logic [3:0]  in_vec1, in_vec0;
    logic        busy1, busy0, done1, done0, match1, match0;
    logic [15:0] table1, table0;
    logic [4:0]  ones1, ones0;

    int checks = 0;
    int errors = 0;

    // Function blocks under sweep, modelled as lookup tables
    assign f_in1 = fn1[in_vec1];
    assign f_in0 = fn0[in_vec0];

    tioe1_sweeper #(.N_IN(4), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .f_in(f_in1), .exp_table(exp1),
        .in_vec(in_vec1), .busy(busy1), .done(done1), .table_out(table1),
        .ones_cnt(ones1), .match(match1)
    );

    tioe1_sweeper #(.N_IN(4), .SETTLE(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .f_in(f_in0), .exp_table(exp0),
        .in_vec(in_vec0), .busy(busy0), .done(done0), .table_out(table0),
        .ones_cnt(ones0), .match(match0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the bench always terminates
    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Truth table of a function given as a per-combination rule
    function automatic logic [15:0] build_tab(input int kind);
        logic [15:0] t;
        t = '0;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            case (kind)
                0: t[i] = v[1] ^ v[0];   // C ^ D
                1: t[i] = 1'b1;
                2: t[i] = 1'b0;
                default: t[i] = v[3];    // A
            endcase
        end
        return t;
    endfunction

    task automatic set_start(input bit fast, input logic v);
        if (fast) start0 = v;
        else      start1 = v;
    endtask

    task automatic get_res(input bit fast, output logic [15:0] tab,
                           output logic [4:0] ones, output logic m);
        tab  = fast ? table0 : table1;
        ones = fast ? ones0  : ones1;
        m    = fast ? match0 : match1;
    endtask

    // Runs one sweep from the current cycle and observes in_vec/busy/done
    // against the ideal schedule: combination j/(SETTLE+1) at cycle j
    task automatic do_sweep(input bit fast, input int pulse_idx, input int rst_idx,
                            output int lat, output int ndone,
                            output int vec_err, output int busy_err);
        int   per;
        int   total;
        bit   pulsed;
        bit   reset_seen;
        logic [3:0] iv;
        logic bz, dn;
        per   = fast ? 1 : 2;
        total = 16 * per;
        pulsed = 0; reset_seen = 0;
        lat = -1; ndone = 0; vec_err = 0; busy_err = 0;
        set_start(fast, 1'b1);
        @(posedge clk); #1;
        set_start(fast, 1'b0);
        for (int j = 0; j <= total + 2; j++) begin
            iv = fast ? in_vec0 : in_vec1;
            bz = fast ? busy0   : busy1;
            dn = fast ? done0   : done1;
            if (!reset_seen) begin
                if (j < total && int'(iv) != j / per) vec_err++;
                if (bz !== (j <= total)) busy_err++;
            end
            if (dn === 1'b1) begin
                ndone++;
                if (lat < 0) lat = j;
            end
            if (pulse_idx >= 0 && !pulsed && !reset_seen && int'(iv) == pulse_idx) begin
                set_start(fast, 1'b1);
                pulsed = 1;
            end
            if (rst_idx >= 0 && !reset_seen && int'(iv) == rst_idx) begin
                rst = 1'b1;
                reset_seen = 1;
            end
            @(posedge clk); #1;
            set_start(fast, 1'b0);
            rst = 1'b0;
        end
    endtask

    // Full sweep plus checks of timing, schedule and results
    task automatic sweep_and_check(input string nm, input bit fast,
                                   input logic [15:0] fn, input logic [15:0] ex);
        int lat, nd, ve, be;
        logic [15:0] tab; logic [4:0] ones; logic m;
        int exp_lat;
        if (fast) begin fn0 = fn; exp0 = ex; end
        else      begin fn1 = fn; exp1 = ex; end
        exp_lat = fast ? 16 : 32;
        do_sweep(fast, -1, -1, lat, nd, ve, be);
        get_res(fast, tab, ones, m);
        checks++; if (lat !== exp_lat) begin errors++; $display("FAIL %s latency got %0d want %0d", nm, lat, exp_lat); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL %s done_pulses got %0d want 1", nm, nd); end
        checks++; if (ve !== 0) begin errors++; $display("FAIL %s in_vec_schedule got %0d errs want 0", nm, ve); end
        checks++; if (be !== 0) begin errors++; $display("FAIL %s busy_window got %0d errs want 0", nm, be); end
        checks++; if (tab !== fn) begin errors++; $display("FAIL %s table_out got %h want %h", nm, tab, fn); end
        checks++; if (ones !== 5'($countones(fn))) begin errors++; $display("FAIL %s ones_cnt got %0d want %0d", nm, ones, $countones(fn)); end
        checks++; if (m !== (fn == ex)) begin errors++; $display("FAIL %s match got %b want %b", nm, m, (fn == ex)); end
    endtask

    task automatic test_reset();
        rst = 1'b1; start1 = 1'b1; start0 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({in_vec1, busy1, done1, table1, ones1, match1} !== '0) begin
            errors++; $display("FAIL reset_dut1 got iv=%h b=%b d=%b t=%h o=%0d m=%b want all 0",
                               in_vec1, busy1, done1, table1, ones1, match1); end
        checks++; if ({in_vec0, busy0, done0, table0, ones0, match0} !== '0) begin
            errors++; $display("FAIL reset_dut0 got iv=%h b=%b d=%b t=%h o=%0d m=%b want all 0",
                               in_vec0, busy0, done0, table0, ones0, match0); end
        rst = 1'b0; start1 = 1'b0; start0 = 1'b0;
        @(posedge clk); #1;
        checks++; if ({busy1, busy0} !== 2'b00) begin errors++; $display("FAIL reset_start_ignored busy got %b%b want 00", busy1, busy0); end
    endtask

    task automatic test_xor();
        logic [15:0] t;
        t = build_tab(0);
        checks++; if (t !== 16'h6666) begin errors++; $display("FAIL xor_model got %h want 6666", t); end
        sweep_and_check("xor", 1'b0, t, 16'h6666);
        repeat (4) @(posedge clk);
        #1;
        checks++; if (table1 !== 16'h6666 || match1 !== 1'b1 || ones1 !== 5'd8) begin
            errors++; $display("FAIL xor_hold got t=%h m=%b o=%0d want 6666 1 8", table1, match1, ones1); end
    endtask

    task automatic test_ones_zeros();
        sweep_and_check("all_ones", 1'b0, build_tab(1), 16'hFFFF);
        @(posedge clk); #1;
        sweep_and_check("all_zeros", 1'b0, build_tab(2), 16'hFFFF);
    endtask

    task automatic test_settle0();
        logic [15:0] t;
        t = build_tab(3);
        checks++; if (t !== 16'hFF00) begin errors++; $display("FAIL fa_model got %h want FF00", t); end
        sweep_and_check("settle0_fA", 1'b1, t, 16'hFF00);
    endtask

    task automatic test_restart_ignored();
        int lat, nd, ve, be;
        fn1 = build_tab(0); exp1 = 16'h6666;
        @(posedge clk); #1;
        do_sweep(1'b0, 5, -1, lat, nd, ve, be);
        checks++; if (lat !== 32 || nd !== 1) begin errors++; $display("FAIL restart_timing got lat=%0d nd=%0d want 32 1", lat, nd); end
        checks++; if (ve !== 0 || be !== 0) begin errors++; $display("FAIL restart_schedule got ve=%0d be=%0d want 0 0", ve, be); end
        checks++; if (table1 !== 16'h6666 || match1 !== 1'b1) begin errors++; $display("FAIL restart_result got t=%h m=%b want 6666 1", table1, match1); end
    endtask

    task automatic test_reset_mid();
        int lat, nd, ve, be;
        fn1 = build_tab(1); exp1 = 16'hFFFF;
        @(posedge clk); #1;
        do_sweep(1'b0, -1, 9, lat, nd, ve, be);
        checks++; if (nd !== 0) begin errors++; $display("FAIL midreset_done got %0d pulses want 0", nd); end
        checks++; if ({in_vec1, busy1, table1, ones1, match1} !== '0) begin
            errors++; $display("FAIL midreset_state got iv=%h b=%b t=%h o=%0d m=%b want all 0",
                               in_vec1, busy1, table1, ones1, match1); end
    endtask

    task automatic test_back_to_back();
        int d_first, d_second, low_cnt;
        d_first = -1; d_second = -1; low_cnt = 0;
        fn1 = build_tab(0); exp1 = 16'h6666;
        start1 = 1'b1;
        @(posedge clk); #1;
        for (int j = 0; j < 90 && d_second < 0; j++) begin
            if (done1 === 1'b1) begin
                if (d_first < 0) d_first = j;
                else             d_second = j;
            end
            if (d_first >= 0 && d_second < 0 && busy1 === 1'b0) low_cnt++;
            if (d_second >= 0) start1 = 1'b0;
            @(posedge clk); #1;
        end
        start1 = 1'b0;
        checks++; if (d_first < 0 || d_second < 0 || (d_second - d_first) !== 34) begin
            errors++; $display("FAIL b2b_spacing got %0d and %0d want 34 apart", d_first, d_second); end
        checks++; if (low_cnt !== 1) begin errors++; $display("FAIL b2b_busy_gap got %0d cycles want 1", low_cnt); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy1 !== 1'b0 || table1 !== 16'h6666) begin errors++; $display("FAIL b2b_end got b=%b t=%h want 0 6666", busy1, table1); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            logic [15:0] fn, ex;
            bit fast;
            fn   = 16'($urandom);
            ex   = ($urandom_range(0, 1) == 1) ? fn : (fn ^ (16'h1 << $urandom_range(0, 15)));
            fast = ($urandom_range(0, 1) == 1);
            @(posedge clk); #1;
            sweep_and_check($sformatf("rand%0d", n), fast, fn, ex);
        end
    endtask

    initial begin
        rst = 1'b1; start1 = 1'b0; start0 = 1'b0;
        fn1 = '0; fn0 = '0; exp1 = '0; exp0 = '0;
        test_reset();
        test_xor();
        test_ones_zeros();
        test_settle0();
        test_restart_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_tioe1_sweeper
`default_nettype wire
